// File: rtl/ext_pkg.sv
// Shared definitions for the immediate/data extension stage: op codes and FSM states.
package ext_pkg;

    localparam int unsigned EXT_OP_W = 3;

    localparam logic [EXT_OP_W-1:0] EXT_ZERO   = 3'b000;
    localparam logic [EXT_OP_W-1:0] EXT_SIGN   = 3'b001;
    localparam logic [EXT_OP_W-1:0] EXT_LUI    = 3'b010;
    localparam logic [EXT_OP_W-1:0] EXT_BRANCH = 3'b011;
    localparam logic [EXT_OP_W-1:0] EXT_LBU    = 3'b100;
    localparam logic [EXT_OP_W-1:0] EXT_LB     = 3'b101;
    localparam logic [EXT_OP_W-1:0] EXT_LHU    = 3'b110;
    localparam logic [EXT_OP_W-1:0] EXT_LH     = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } ext_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extender: op/imm/load data/byte offset -> {err, result}.
// Load modes (LBU/LB/LHU/LH) exist only when EXT_LOAD_EN is defined; they assume DATA_W >= 32.
module imm_ext_core
    import ext_pkg::*;
#(
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic [EXT_OP_W-1:0] op,
    input  logic [IMM_W-1:0]    imm,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic [1:0]          boff,
    output logic [DATA_W-1:0]   res,
    output logic                err
);

    logic [DATA_W-1:0] sign_ext;
    assign sign_ext = DATA_W'($signed(imm));

`ifdef EXT_LOAD_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    assign ld_byte = ld_data[{boff, 3'b000} +: 8];
    assign ld_half = ld_data[{boff[1], 4'b0000} +: 16];
`else
    logic unused_ld;
    assign unused_ld = ^{ld_data, boff};
`endif

    always_comb begin
        res = '0;
        err = 1'b0;
        case (op)
            EXT_ZERO:   res = DATA_W'(imm);
            EXT_SIGN:   res = sign_ext;
            EXT_LUI:    res = DATA_W'(imm) << (DATA_W - IMM_W);
            EXT_BRANCH: res = sign_ext << BR_SHIFT;
`ifdef EXT_LOAD_EN
            EXT_LBU:    res = DATA_W'(ld_byte);
            EXT_LB:     res = DATA_W'($signed(ld_byte));
            EXT_LHU: begin
                if (boff[0]) err = 1'b1;
                else         res = DATA_W'(ld_half);
            end
            EXT_LH: begin
                if (boff[0]) err = 1'b1;
                else         res = DATA_W'($signed(ld_half));
            end
`endif
            default:    err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered valid/ready extension stage with a one-entry skid behind the output register.
// EXT_LOAD_EN enables the load-extension modes inside imm_ext_core.
module imm_ext_stage
    import ext_pkg::*;
#(
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EXT_OP_W-1:0] in_op,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_boff,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_err
);

    ext_state_t        state, state_next;
    logic [DATA_W-1:0] core_data, skid_data;
    logic              core_err, skid_err;
    logic              accept;
    logic              load_out, load_skid, move_skid, clr_err;

    imm_ext_core #(
        .IMM_W   (IMM_W),
        .DATA_W  (DATA_W),
        .BR_SHIFT(BR_SHIFT)
    ) u_core (
        .op     (in_op),
        .imm    (in_imm),
        .ld_data(in_data),
        .boff   (in_boff),
        .res    (core_data),
        .err    (core_err)
    );

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_EMPTY;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        clr_err    = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
            clr_err    = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next = ST_ONE;
                        load_out   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !out_ready) begin
                        state_next = ST_TWO;
                        load_skid  = 1'b1;
                    end else if (accept) begin
                        load_out   = 1'b1;
                    end else if (out_ready) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        state_next = ST_ONE;
                        move_skid  = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // Flush clears only the error flag; out_data keeps its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_err   <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (clr_err) begin
                out_err <= 1'b0;
            end else if (load_out) begin
                out_data <= core_data;
                out_err  <= core_err;
            end else if (move_skid) begin
                out_data <= skid_data;
                out_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= core_data;
                skid_err  <= core_err;
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed self-checking bench for imm_ext_stage (default parameters).
module tb_imm_ext_stage;
    import ext_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_imm;
    logic [31:0] in_data;
    logic [1:0]  in_boff;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    imm_ext_stage #(
        .IMM_W   (16),
        .DATA_W  (32),
        .BR_SHIFT(2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_imm   (in_imm),
        .in_data  (in_data),
        .in_boff  (in_boff),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset out_data: got %h expected 00000000", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset out_err: got %b expected 0", out_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post-reset out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_modes();
        logic [2:0]  ops  [6] = '{EXT_SIGN, EXT_LUI, EXT_BRANCH, EXT_ZERO, EXT_SIGN, EXT_BRANCH};
        logic [15:0] imms [6] = '{16'h8001, 16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000};
        logic [31:0] exps [6] = '{32'hFFFF8001, 32'h12340000, 32'hFFFFFFFC,
                                  32'h00008000, 32'h00007FFF, 32'hFFFE0000};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_op    = ops[i];
            in_imm   = imms[i];
            cycle();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL modes out_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL modes out_data[%0d]: got %h expected %h", i, out_data, exps[i]); end
            checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL modes out_err[%0d]: got %b expected 0", i, out_err); end
        end
        in_valid = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL modes drain out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = EXT_ZERO;
        in_imm    = 16'h0001;
        cycle();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b first in_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL b2b first out_data: got %h expected 00000001", out_data); end
        in_imm = 16'h0002;
        cycle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b full in_ready: got %b expected 0", in_ready); end
        checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL b2b full out_data: got %h expected 00000001", out_data); end
        in_imm = 16'h0003;
        cycle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b stall in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b stall out_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL b2b hold out_data: got %h expected 00000001", out_data); end
        out_ready = 1'b1;
        cycle();
        checks++; if (out_data !== 32'h2) begin errors++; $display("FAIL b2b drain2 out_data: got %h expected 00000002", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b drain2 in_ready: got %b expected 1", in_ready); end
        cycle();
        checks++; if (out_data !== 32'h3) begin errors++; $display("FAIL b2b third out_data: got %h expected 00000003", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b third out_valid: got %b expected 1", out_valid); end
        in_valid = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b empty out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b empty in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_flush();
        // Illegal op 111 with boff=1 errors in both build configurations.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = EXT_LH;
        in_imm    = 16'h0000;
        in_boff   = 2'd1;
        cycle();
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL flush pre out_err: got %b expected 1", out_err); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL flush pre out_data: got %h expected 00000000", out_data); end
        in_op   = EXT_ZERO;
        in_imm  = 16'h0022;
        in_boff = 2'd0;
        cycle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush two in_ready: got %b expected 0", in_ready); end
        in_imm = 16'h0033;
        flush  = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush in_ready: got %b expected 1", in_ready); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL flush out_err: got %b expected 0", out_err); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush dropped out_valid[%0d]: got %b expected 0", i, out_valid); end
        end
        in_valid = 1'b1;
        in_imm   = 16'h0011;
        cycle();
        checks++; if (out_data !== 32'h11) begin errors++; $display("FAIL flush next out_data: got %h expected 00000011", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush next out_valid: got %b expected 1", out_valid); end
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush one out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h11) begin errors++; $display("FAIL flush hold out_data: got %h expected 00000011", out_data); end
        out_ready = 1'b1;
    endtask

    task automatic test_load();
`ifdef EXT_LOAD_EN
        localparam int N = 7;
        logic [2:0]  ops  [N] = '{EXT_LB, EXT_LHU, EXT_LH, EXT_LBU, EXT_LB, EXT_LH, EXT_LH};
        logic [1:0]  offs [N] = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd2};
        logic [31:0] exps [N] = '{32'hFFFFFFFF, 32'h000080FF, 32'h00000000, 32'h00000080,
                                  32'h00000001, 32'h00007F01, 32'hFFFF80FF};
        logic        errs [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        localparam int N = 4;
        logic [2:0]  ops  [N] = '{EXT_LB, EXT_LBU, EXT_LHU, EXT_LH};
        logic [1:0]  offs [N] = '{2'd2, 2'd0, 2'd2, 2'd0};
        logic [31:0] exps [N] = '{32'h0, 32'h0, 32'h0, 32'h0};
        logic        errs [N] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        out_ready = 1'b1;
        in_data   = 32'h80FF7F01;
        in_imm    = 16'h1234;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_op    = ops[i];
            in_boff  = offs[i];
            cycle();
            checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL load out_data[%0d]: got %h expected %h", i, out_data, exps[i]); end
            checks++; if (out_err !== errs[i]) begin errors++; $display("FAIL load out_err[%0d]: got %b expected %b", i, out_err, errs[i]); end
        end
        in_valid = 1'b0;
        in_boff  = 2'd0;
        cycle();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = EXT_SIGN;
        in_imm    = 16'h8001;
        cycle();
        in_op = EXT_BRANCH;
        in_imm = 16'h0001;
        cycle();
        in_valid = 1'b0;
        checks++; if (out_data !== 32'hFFFF8001) begin errors++; $display("FAIL areset pre out_data: got %h expected ffff8001", out_data); end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL areset out_data: got %h expected 00000000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset release out_valid: got %b expected 0", out_valid); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = EXT_SIGN;
        in_imm    = 16'h8001;
        cycle();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset latency out_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'hFFFF8001) begin errors++; $display("FAIL areset first out_data: got %h expected ffff8001", out_data); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset drain out_valid: got %b expected 0", out_valid); end
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = EXT_ZERO;
        in_imm    = '0;
        in_data   = '0;
        in_boff   = '0;
        out_ready = 1'b1;
        test_reset();
        test_modes();
        test_back_to_back();
        test_flush();
        test_load();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
